fixed_add_acc_pipe: RTL

//  Pipelined signed fixed-point adder/accumulator replacing the combinational pairwise adder.

---
 rtl/fixed_add_acc_pipe_if.sv | 36 +++
 rtl/fixed_add_acc_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fixed_add_acc_pipe_if.sv
// ---------------------------------------------------------------------------
// fixed_add_acc_pipe_if
// Purpose : valid/ready bundle between the MAC array (upstream), the
//           fixed_add_acc_pipe block and the activation stage (downstream).
// Signals : in_valid/in_ready/in_a/in_b/in_last/acc_mode  operand beat side
//           out_valid/out_ready/out_sum/out_count/out_ovf   result side
// Modports: master - traffic source/sink that talks to the block
//           slave  - the adder/accumulator block itself
// ---------------------------------------------------------------------------
interface fixed_add_acc_pipe_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 17,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_a;
  logic [IN_W-1:0]  in_b;
  logic             in_last;
  logic             acc_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, acc_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, acc_mode, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/fixed_add_acc_pipe.sv
// ---------------------------------------------------------------------------
// fixed_add_acc_pipe
// Purpose : two-stage pipelined signed fixed-point adder/accumulator.
//           ADD mode emits a+b for every beat; ACC mode sums every a+b of a
//           packet (closed by in_last) and emits one result.
// Ports   : clk    - rising-edge clock
//           reset  - asynchronous, active-high
//           bus    - fixed_add_acc_pipe_if.slave (operand and result
//                    valid/ready channels, see the interface file)
// Config  : FIXED_ADD_SAT_EN - when defined the ACC result saturates, stays
//           clamped for the rest of the packet and raises out_ovf. When not
//           defined the accumulator wraps and out_ovf is always 0.
// ---------------------------------------------------------------------------
module fixed_add_acc_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 17,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  fixed_add_acc_pipe_if.slave bus
);

  logic                    rdy_q;
  logic                    stall;
  logic                    accept;

  // input-side packet tracking (mode is frozen for an open ACC packet)
  logic                    in_open;
  logic                    in_mode;
  logic                    eff_mode;

  // stage 1
  logic                    s1_valid;
  logic                    s1_last;
  logic                    s1_mode;
  logic signed [IN_W:0]    s1_p;

  // stage 2 / accumulator
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] p_ext;
  logic signed [OUT_W-1:0] acc_next;
  logic                    acc_ovf_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;

  // registered outputs
  logic                    ov_q;
  logic signed [OUT_W-1:0] osum_q;
  logic [CNT_W-1:0]        ocnt_q;
  logic                    oovf_q;

  assign stall        = ov_q && !bus.out_ready;
  // rdy_q keeps in_ready low throughout reset and rises on the first edge after
  assign bus.in_ready = rdy_q && !stall;
  assign accept       = bus.in_valid && bus.in_ready;
  assign eff_mode     = in_open ? in_mode : bus.acc_mode;

  assign p_ext    = OUT_W'(s1_p);
  assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef FIXED_ADD_SAT_EN
  localparam logic signed [OUT_W-1:0] ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    sat_q;
  logic signed [OUT_W:0]   wide;

  assign wide = (OUT_W+1)'(acc) + (OUT_W+1)'(p_ext);

  // once clamped the accumulator ignores the rest of the packet
  always_comb begin
    acc_next     = wide[OUT_W-1:0];
    acc_ovf_next = 1'b0;
    if (sat_q) begin
      acc_next     = acc;
      acc_ovf_next = 1'b1;
    end else if (wide[OUT_W] != wide[OUT_W-1]) begin
      acc_next     = wide[OUT_W] ? ACC_MIN : ACC_MAX;
      acc_ovf_next = 1'b1;
    end
  end
`else
  assign acc_next     = acc + p_ext;
  assign acc_ovf_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q    <= 1'b0;
      in_open  <= 1'b0;
      in_mode  <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
      s1_p     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ov_q     <= 1'b0;
      osum_q   <= '0;
      ocnt_q   <= '0;
      oovf_q   <= 1'b0;
`ifdef FIXED_ADD_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b1;
      if (!stall) begin
        s1_valid <= accept;
        if (accept) begin
          s1_p    <= (IN_W+1)'($signed(bus.in_a)) + (IN_W+1)'($signed(bus.in_b));
          s1_mode <= eff_mode;
          // ADD beats always close their own "packet"
          s1_last <= eff_mode ? bus.in_last : 1'b1;
          in_mode <= eff_mode;
          if (eff_mode) begin
            in_open <= !bus.in_last;
          end
        end

        ov_q <= 1'b0;
        if (s1_valid) begin
          if (!s1_mode) begin
            ov_q   <= 1'b1;
            osum_q <= p_ext;
            ocnt_q <= CNT_W'(1);
            oovf_q <= 1'b0;
          end else if (s1_last) begin
            // result leaves and the accumulator clears in the same cycle
            ov_q   <= 1'b1;
            osum_q <= acc_next;
            ocnt_q <= cnt_next;
            oovf_q <= acc_ovf_next;
            acc    <= '0;
            cnt    <= '0;
`ifdef FIXED_ADD_SAT_EN
            sat_q  <= 1'b0;
`endif
          end else begin
            acc <= acc_next;
            cnt <= cnt_next;
`ifdef FIXED_ADD_SAT_EN
            sat_q <= acc_ovf_next;
`endif
          end
        end
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_sum   = osum_q;
  assign bus.out_count = ocnt_q;
  assign bus.out_ovf   = oovf_q;

endmodule
